// File: rtl/vm_pkg.sv
// Shared change-dispenser definitions.
// Purpose: controller state enumeration, hopper coin_sel encodings and the
//          coin denomination values used by the greedy selector.
// Ports:   none (package).
package vm_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PICK    = 3'd1,
      REQ     = 3'd2,
      RELEASE = 3'd3,
      DONE    = 3'd4,
      FAULT   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      COIN_1  = 2'b00,
      COIN_5  = 2'b01,
      COIN_10 = 2'b10,
      COIN_50 = 2'b11
   } coin_t;

   localparam logic [7:0] DENOM_1  = 8'd1;
   localparam logic [7:0] DENOM_5  = 8'd5;
   localparam logic [7:0] DENOM_10 = 8'd10;
   localparam logic [7:0] DENOM_50 = 8'd50;

endpackage

// File: rtl/change_dispenser_if.sv
// Change dispenser bus: sell-stage request, hopper handshake and status.
// Ports (signals):
//   start, charge_in      - payout request from the sell stage
//   coin_req/coin_sel,
//   coin_ack              - 4-phase handshake with the coin hopper
//   busy, done, fault,
//   remaining, coin_count - payout status
// Modports: master = sell stage + hopper side, slave = dispenser.
interface change_dispenser_if;
   logic       start;
   logic [7:0] charge_in;
   logic       coin_ack;
   logic       coin_req;
   logic [1:0] coin_sel;
   logic       busy;
   logic       done;
   logic       fault;
   logic [7:0] remaining;
   logic [7:0] coin_count;

   modport master (
      output start, charge_in, coin_ack,
      input  coin_req, coin_sel, busy, done, fault, remaining, coin_count
   );

   modport slave (
      input  start, charge_in, coin_ack,
      output coin_req, coin_sel, busy, done, fault, remaining, coin_count
   );
endinterface

// File: rtl/coin_pick.sv
// Greedy coin selector (combinational).
// Purpose: choose the largest denomination not exceeding the amount owed.
// Ports:
//   remaining [7:0] in  - change still owed
//   sel       [1:0] out - coin_sel encoding of the chosen coin
//   value     [7:0] out - face value of the chosen coin
// With remaining=0 the outputs fall back to the 1-unit coin; the caller
// never ejects a coin in that case.
module coin_pick
   import vm_pkg::*;
(
   input  logic [7:0] remaining,
   output logic [1:0] sel,
   output logic [7:0] value
);

   always_comb begin
      sel   = COIN_1;
      value = DENOM_1;
      if (remaining >= DENOM_50) begin
         sel   = COIN_50;
         value = DENOM_50;
      end else if (remaining >= DENOM_10) begin
         sel   = COIN_10;
         value = DENOM_10;
      end else if (remaining >= DENOM_5) begin
         sel   = COIN_5;
         value = DENOM_5;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser controller.
// Purpose: pays out charge_in as a greedy sequence of coins, one 4-phase
//          hopper handshake per coin, with a per-phase timeout that parks
//          the controller in FAULT until the next start.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - change_dispenser_if.slave (start/charge_in in, hopper handshake,
//         busy/done/fault/remaining/coin_count status out)
// Parameter TIMEOUT: cycles allowed per handshake phase before FAULT.
module change_dispenser
   import vm_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   change_dispenser_if.slave  bus
);

   localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

   state_t     state_reg, state_next;
   logic [7:0] remaining_reg, remaining_next;
   logic [7:0] count_reg, count_next;
   logic [7:0] timer_reg, timer_next;
   logic [1:0] sel_reg, sel_next;
   logic       req_reg, done_reg, fault_reg, busy_reg;
   logic [1:0] pick_sel;
   logic [7:0] pick_value;
   logic [7:0] timer_inc;

   coin_pick u_pick (
      .remaining (remaining_reg),
      .sel       (pick_sel),
      .value     (pick_value)
   );

   assign timer_inc = timer_reg + 8'd1;

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      count_next     = count_reg;
      timer_next     = timer_reg;
      sel_next       = sel_reg;
      case (state_reg)
         IDLE, FAULT: begin
            if (bus.start) begin
               remaining_next = bus.charge_in;
               count_next     = 8'd0;
               timer_next     = 8'd0;
               state_next     = PICK;
            end
         end
         PICK: begin
            if (remaining_reg == 8'd0) begin
               state_next = DONE;
            end else begin
               sel_next   = pick_sel;
               timer_next = 8'd0;
               state_next = REQ;
            end
         end
         REQ: begin
            if (bus.coin_ack) begin
               // remaining_reg has not moved since PICK, so pick_value is
               // still the value of the coin held in sel_reg.
               remaining_next = remaining_reg - pick_value;
               count_next     = count_reg + 8'd1;
               timer_next     = 8'd0;
               state_next     = RELEASE;
            end else begin
               timer_next = timer_inc;
               if (timer_inc == TIMEOUT_L) begin
                  state_next = FAULT;
               end
            end
         end
         RELEASE: begin
            if (!bus.coin_ack) begin
               state_next = PICK;
            end else begin
               timer_next = timer_inc;
               if (timer_inc == TIMEOUT_L) begin
                  state_next = FAULT;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so that coin_req, busy and
   // fault are plain flops; done is delayed one cycle from the DONE state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         remaining_reg <= 8'd0;
         count_reg     <= 8'd0;
         timer_reg     <= 8'd0;
         sel_reg       <= COIN_1;
         req_reg       <= 1'b0;
         done_reg      <= 1'b0;
         fault_reg     <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         count_reg     <= count_next;
         timer_reg     <= timer_next;
         sel_reg       <= sel_next;
         req_reg       <= (state_next == REQ);
         done_reg      <= (state_reg == DONE);
         fault_reg     <= (state_next == FAULT);
         busy_reg      <= (state_next == PICK) || (state_next == REQ) ||
                          (state_next == RELEASE);
      end
   end

   assign bus.coin_req   = req_reg;
   assign bus.coin_sel   = sel_reg;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.fault      = fault_reg;
   assign bus.remaining  = remaining_reg;
   assign bus.coin_count = count_reg;

endmodule
